game_controller: RTL
====================

# game_controller

Top-level sequencer for the 2048 board. It owns the 4x4 board register and accepts one direction command at a time. Each move is processed one line per cycle through a shared slide/merge datapath, then one new 2 or 4 tile is spawned into a pseudo-randomly selected empty cell. Afterwards it evaluates win/lose. It sits between the debounced button front-end and the display/VGA renderer.

## Interface
- `WIN_TILE`, default 2048: tile value that ends the game as a win.
- `LFSR_SEED`, default 16'hACE1: reset value of the spawn LFSR; must be non-zero.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `btn` input, 4 bits: direction request, one cycle pulse. Bit 3 is up, 2 is down, 1 is left, 0 is right.
- `load_en` input, 1 bit: when high in IDLE, copies `load_board` into the board (bench/debug preload).
- `load_board` input, 12x4x4: board image for `load_en`.
- `board` output, 12x4x4: current board; `board[r][c]`, row 0 is top, column 0 is left. Reset value: all zero.
- `busy` output, 1 bit: high whenever state is not IDLE/WIN/LOSE. Reset value 1.
- `win` output, 1 bit: sticky. Reset value 0.
- `lose` output, 1 bit: sticky. Reset value 0.
- `score` output, 16 bits: present only with `GAME_SCORE_EN`. Reset value 0.

## Operation
- States: INIT_A, INIT_B, IDLE, MOVE, SPAWN, CHECK, WIN, LOSE.
- On `rst`:
  - board cleared, LFSR set to `LFSR_SEED`, state INIT_A.
  - INIT_A and INIT_B each spawn one tile, then state goes to IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, including in IDLE.
- IDLE:
  - `load_en` has priority over `btn`; a load takes one cycle and the state stays IDLE.
  - With any `btn` bit set, the direction is latched with priority up > down > left > right; state goes to MOVE, and a line index starts at 0.
- MOVE: four cycles, one line per cycle (columns for up/down, rows for left/right).
  - Each line is read in order from the destination wall outward.
  - The line is passed through `line_merge`, and the result is written back in the same order.
  - `moved` is ORed with the line's changed flag.
  - After line 3: if `moved` is set, go to SPAWN; otherwise go to IDLE with the board unchanged and no spawn.
- line_merge rule:
  - Compact non-zeros toward index 0.
  - Then scan from index 0: equal adjacent pairs merge into 2x the value, and the remainder shifts down.
  - A tile merges at most once per move. Example: [2,2,2,2] becomes [4,4,0,0]; [4,0,4,8] becomes [8,8,0,0].
- SPAWN (also used by INIT_A/B):
  - Zero count z is 0..16, 5 bits.
  - Target position p = `lfsr[7:0]` mod z.
  - The p-th zero is counted in row-major order (r outer, c inner).
  - Written value is 4 if p is odd, else 2.
  - If z = 0, nothing is written.
- CHECK:
  - If any tile equals `WIN_TILE`, set `win` and go to WIN.
  - Else, if there is no zero tile and no horizontally or vertically adjacent equal pair, set `lose` and go to LOSE.
  - Otherwise go to IDLE.
- WIN and LOSE are terminal. `btn` and `load_en` are ignored there; only `rst` exits.
- `btn` asserted outside IDLE is dropped, not queued.

## Timing
- Button sampled in IDLE at cycle N:
  - MOVE occupies N+1..N+4, lines 0..3.
  - SPAWN is at N+5 and CHECK at N+6.
  - `board` shows the spawned tile from N+6.
  - `win`/`lose` and return to IDLE are visible at N+7.
- No-change move: back to IDLE at N+5; `busy` is high N+1..N+4.
- After `rst` is released at cycle R: INIT_A at R+1, INIT_B at R+2, IDLE at R+3. `busy` is low from R+3.
- `rst` asserted in any state, including mid-MOVE, takes precedence. The partially moved board is discarded.
- `load_en` takes effect one cycle after sampling.

## Configuration
- `GAME_SCORE_EN` defined:
  - `score` port exists.
  - In MOVE, every merge adds the merged value, saturating at 16'hFFFF.
  - Cleared on `rst` and on `load_en`.
- Undefined: no `score` port, no score logic, and `line_merge` score output left unconnected.

## Structure
- Package `game_pkg`:
  - `tile_t` (logic [11:0]).
  - `dir_t` enum (UP, DOWN, LEFT, RIGHT).
  - `ctrl_state_t` enum.
  - Constants `BOARD_N`=4, `LFSR_TAPS`, default `WIN_TILE`.
- Sub-module `line_merge`: combinational.
  - Inputs: 4 `tile_t`.
  - Outputs: 4 `tile_t`, `changed`, a 16-bit merge sum.

## Test plan
- Reset: hold `rst` 2 cycles, release → `busy` low after exactly 3 cycles, exactly two non-zero tiles, each 2 or 4.
- Load row0=[2,2,2,2], rest 0, press left:
  - row0 becomes [4,4,0,0] plus exactly one new tile at a previously-zero cell.
  - `busy` is high for 6 cycles.
  - With `GAME_SCORE_EN`, `score` = 8.
- Load row0=[2,4,8,16], rest 0, press left → no change, no spawn, IDLE after 4 busy cycles.
- Load row0=[1024,1024,0,0], press left → `win`=1 at N+7; later `btn` pulses leave the board unchanged.
- Load a full checkerboard with no adjacent equal tiles except row0=[2,2,4,8], press left → merge, spawn into the single freed cell; CHECK sets `lose` only if no pair remains.
- Press a button during MOVE, and assert `rst` at N+2 → the extra press is ignored; reset clears the board and restarts INIT.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the 2048 board sequencer.
// Tiles are 12-bit values; the board is 4x4 row-major, row 0 on top.
package game_pkg;

  localparam int BOARD_N = 4;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [11:0] tile_t;
  typedef tile_t [BOARD_N-1:0] line_t;
  typedef line_t [BOARD_N-1:0] board_t;

  localparam tile_t WIN_TILE_DEFAULT = 12'd2048;

  typedef enum logic [1:0] {
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  typedef enum logic [2:0] {
    INIT_A,
    INIT_B,
    IDLE,
    MOVE,
    SPAWN,
    CHECK,
    WIN,
    LOSE
  } ctrl_state_t;

endpackage

// File: rtl/game_controller_line_merge.sv
// line_merge: slides one 4-tile line toward index 0 and merges pairs.
// Purely combinational; reports changed flag and sum of merged values.
module line_merge
  import game_pkg::*;
(
  input  line_t       line_in,
  output line_t       line_out,
  output logic        changed,
  output logic [15:0] sum
);

  line_t      c;
  logic [2:0] eq;

  function automatic tile_t dbl(input tile_t t);
    return {t[10:0], 1'b0};
  endfunction

  function automatic logic [15:0] wide(input tile_t t);
    return {3'b000, t, 1'b0};
  endfunction

  always_comb begin
    c = '0;
    for (int k = BOARD_N - 1; k >= 0; k--) begin
      if (line_in[k] != '0) c = {c[BOARD_N-2:0], line_in[k]};
    end
  end

  assign eq[0] = (c[0] != '0) && (c[0] == c[1]);
  assign eq[1] = (c[1] != '0) && (c[1] == c[2]);
  assign eq[2] = (c[2] != '0) && (c[2] == c[3]);

  // Compacted zeros sit at the tail, so three pair cases cover every merge.
  always_comb begin
    line_out = c;
    sum      = '0;
    if (eq[0]) begin
      line_out[0] = dbl(c[0]);
      line_out[3] = '0;
      sum         = wide(c[0]);
      if (eq[2]) begin
        line_out[1] = dbl(c[2]);
        line_out[2] = '0;
        sum         = wide(c[0]) + wide(c[2]);
      end else begin
        line_out[1] = c[2];
        line_out[2] = c[3];
      end
    end else if (eq[1]) begin
      line_out[1] = dbl(c[1]);
      line_out[2] = c[3];
      line_out[3] = '0;
      sum         = wide(c[1]);
    end else if (eq[2]) begin
      line_out[2] = dbl(c[2]);
      line_out[3] = '0;
      sum         = wide(c[2]);
    end
  end

  assign changed = (line_out != line_in);

endmodule

// File: rtl/game_controller.sv
// game_controller: 2048 board sequencer (move, spawn, win/lose check).
// Optional GAME_SCORE_EN adds a saturating 16-bit score port.
module game_controller
  import game_pkg::*;
#(
  parameter tile_t       WIN_TILE  = WIN_TILE_DEFAULT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       load_en,
  input  board_t     load_board,
  output board_t     board,
  output logic       busy,
  output logic       win,
  output logic       lose
`ifdef GAME_SCORE_EN
  ,
  output logic [15:0] score
`endif
);

  ctrl_state_t state, state_n;
  dir_t        dir, dir_n;
  logic [1:0]  idx, idx_n;
  logic        moved, moved_n;
  logic [15:0] lfsr;
  board_t      board_n, spawn_b;
  logic        win_n, lose_n;
  line_t       line_in, line_out;
  logic        changed;
  logic [15:0] msum;
  logic [4:0]  zcnt, zdiv, pos, seen;
  logic        win_hit, has_pair;

  line_merge u_merge (
    .line_in (line_in),
    .line_out(line_out),
    .changed (changed),
`ifdef GAME_SCORE_EN
    .sum     (msum)
`else
    .sum     ()
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // Lines are read from the destination wall outward.
  always_comb begin
    line_in = '0;
    for (int k = 0; k < BOARD_N; k++) begin
      unique case (dir)
        UP:      line_in[k] = board[k][idx];
        DOWN:    line_in[k] = board[BOARD_N-1-k][idx];
        LEFT:    line_in[k] = board[idx][k];
        default: line_in[k] = board[idx][BOARD_N-1-k];
      endcase
    end
  end

  always_comb begin
    zcnt = '0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        if (board[r][c] == '0) zcnt = zcnt + 5'd1;
  end

  assign zdiv = (zcnt == '0) ? 5'd1 : zcnt;
  assign pos  = 5'(lfsr[7:0] % {3'b000, zdiv});

  always_comb begin
    spawn_b = board;
    seen    = '0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        if (board[r][c] == '0) begin
          if (seen == pos) spawn_b[r][c] = pos[0] ? 12'd4 : 12'd2;
          seen = seen + 5'd1;
        end
  end

  always_comb begin
    win_hit  = 1'b0;
    has_pair = 1'b0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        if (board[r][c] == WIN_TILE) win_hit = 1'b1;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N - 1; c++)
        if (board[r][c] == board[r][c+1]) has_pair = 1'b1;
    for (int r = 0; r < BOARD_N - 1; r++)
      for (int c = 0; c < BOARD_N; c++)
        if (board[r][c] == board[r+1][c]) has_pair = 1'b1;
  end

  always_comb begin
    state_n = state;
    board_n = board;
    dir_n   = dir;
    idx_n   = idx;
    moved_n = moved;
    win_n   = win;
    lose_n  = lose;
    unique case (state)
      INIT_A: begin
        board_n = spawn_b;
        state_n = INIT_B;
      end
      INIT_B: begin
        board_n = spawn_b;
        state_n = IDLE;
      end
      IDLE: begin
        if (load_en) begin
          board_n = load_board;
        end else if (|btn) begin
          priority case (1'b1)
            btn[3]:  dir_n = UP;
            btn[2]:  dir_n = DOWN;
            btn[1]:  dir_n = LEFT;
            default: dir_n = RIGHT;
          endcase
          idx_n   = '0;
          moved_n = 1'b0;
          state_n = MOVE;
        end
      end
      MOVE: begin
        for (int k = 0; k < BOARD_N; k++) begin
          unique case (dir)
            UP:      board_n[k][idx] = line_out[k];
            DOWN:    board_n[BOARD_N-1-k][idx] = line_out[k];
            LEFT:    board_n[idx][k] = line_out[k];
            default: board_n[idx][BOARD_N-1-k] = line_out[k];
          endcase
        end
        moved_n = moved | changed;
        idx_n   = idx + 2'd1;
        if (idx == 2'd3) state_n = (moved | changed) ? SPAWN : IDLE;
      end
      SPAWN: begin
        board_n = spawn_b;
        state_n = CHECK;
      end
      CHECK: begin
        if (win_hit) begin
          win_n   = 1'b1;
          state_n = WIN;
        end else if (zcnt == '0 && !has_pair) begin
          lose_n  = 1'b1;
          state_n = LOSE;
        end else begin
          state_n = IDLE;
        end
      end
      WIN:  state_n = WIN;
      LOSE: state_n = LOSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_A;
      board <= '0;
      dir   <= UP;
      idx   <= '0;
      moved <= 1'b0;
      win   <= 1'b0;
      lose  <= 1'b0;
    end else begin
      state <= state_n;
      board <= board_n;
      dir   <= dir_n;
      idx   <= idx_n;
      moved <= moved_n;
      win   <= win_n;
      lose  <= lose_n;
    end
  end

  assign busy = !(state inside {IDLE, WIN, LOSE});

`ifdef GAME_SCORE_EN
  logic [16:0] score_add;
  assign score_add = {1'b0, score} + {1'b0, msum};

  always_ff @(posedge clk) begin
    if (rst)                       score <= '0;
    else if (state == IDLE && load_en) score <= '0;
    else if (state == MOVE)        score <= score_add[16] ? 16'hFFFF : score_add[15:0];
  end
`endif

endmodule
